// File: rtl/systolic_pkg.sv
// Shared types for the systolic-array front end: the feeder FSM state and the
// width of its step counter.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FEEDING = 2'd1,
        DONE    = 2'd2
    } feeder_state_t;

    // Step counter must hold 0..2N-2, i.e. $clog2(2N-1) bits.
    function automatic int step_cnt_w(input int n);
        return (2 * n - 1 > 1) ? $clog2(2 * n - 1) : 1;
    endfunction

endpackage

// File: rtl/input_skew_feeder.sv
// Holds one NxN operand matrix and streams it into an array edge with lane r
// delayed r cycles. Define INPUT_FEEDER_TRANSPOSE_EN for a column-major read.
module input_skew_feeder
    import systolic_pkg::*;
#(
    parameter  int N          = 3,
    parameter  int DATA_WIDTH = 32,
    parameter  int SRAM_DEPTH = N * N,
    localparam int ADDR_W     = (SRAM_DEPTH > 1) ? $clog2(SRAM_DEPTH) : 1
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         write_enable_i,
    input  logic [ADDR_W-1:0]            write_addr_i,
    input  logic [DATA_WIDTH-1:0]        write_data_i,
    input  logic                         start_i,
    output logic [0:N-1][DATA_WIDTH-1:0] data_o,
    output logic [N-1:0]                 valid_o,
    output logic                         busy_o,
    output logic                         feed_done_o
);

    localparam int STEP_W = step_cnt_w(N);
    // One tick past the last step: every lane index is out of range there, so
    // the lane logic naturally produces zeros while feed_done_o is raised.
    localparam logic [STEP_W-1:0] DRAIN_STEP = STEP_W'(2 * N - 1);

    feeder_state_t                r_state;
    logic [STEP_W-1:0]            r_step;
    logic [DATA_WIDTH-1:0]        r_mem [SRAM_DEPTH];
    logic [0:N-1][DATA_WIDTH-1:0] r_data;
    logic [N-1:0]                 r_valid;
    logic                         r_busy;
    logic                         r_done;

    logic                         w_addr_ok;
    logic                         w_wr_commit;
    logic [0:N-1][DATA_WIDTH-1:0] w_lane_data;
    logic [N-1:0]                 w_lane_vld;

    assign w_addr_ok   = {1'b0, write_addr_i} < (ADDR_W + 1)'(SRAM_DEPTH);
    assign w_wr_commit = (r_state == IDLE) && write_enable_i && w_addr_ok;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < SRAM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_commit) begin
            r_mem[write_addr_i] <= write_data_i;
        end
    end

    // Skew by index arithmetic: lane r reads element k = t - r, kept signed so
    // t < r falls out as "not yet valid" rather than wrapping.
    always_comb begin
        int k;
        int addr;
        k           = 0;
        addr        = 0;
        w_lane_data = '0;
        w_lane_vld  = '0;
        for (int r = 0; r < N; r++) begin
            k = int'(r_step) - r;
            if (k >= 0 && k < N) begin
`ifdef INPUT_FEEDER_TRANSPOSE_EN
                addr = k * N + r;
`else
                addr = r * N + k;
`endif
                w_lane_vld[r]  = 1'b1;
                w_lane_data[r] = r_mem[addr[ADDR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_data  <= '0;
            r_valid <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= FEEDING;
                        r_step  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                FEEDING: begin
                    r_data  <= w_lane_data;
                    r_valid <= w_lane_vld;
                    if (r_step == DRAIN_STEP) begin
                        r_state <= DONE;
                        r_step  <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_step <= r_step + STEP_W'(1);
                    end
                end
                DONE: begin
                    r_done <= 1'b0;
                    // Back-to-back pass: the edge leaving DONE may launch again.
                    if (start_i) begin
                        r_state <= FEEDING;
                        r_step  <= '0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign busy_o      = r_busy;
    assign feed_done_o = r_done;

endmodule

// File: tb/tb_input_skew_feeder.sv
// Scoreboard bench for input_skew_feeder: each pass pushes its expected output
// frames; a negedge monitor pops and compares whenever the DUT drives a frame.
module tb_input_skew_feeder;

    localparam int N     = 3;
    localparam int DW    = 32;
    localparam int DEPTH = N * N;
    localparam int AW    = $clog2(DEPTH);

    logic                 clk_i = 1'b0;
    logic                 rstn_i = 1'b0;
    logic                 write_enable_i = 1'b0;
    logic [AW-1:0]        write_addr_i = '0;
    logic [DW-1:0]        write_data_i = '0;
    logic                 start_i = 1'b0;
    logic [0:N-1][DW-1:0] data_o;
    logic [N-1:0]         valid_o;
    logic                 busy_o;
    logic                 feed_done_o;

    input_skew_feeder #(.N(N), .DATA_WIDTH(DW), .SRAM_DEPTH(DEPTH)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .write_enable_i (write_enable_i),
        .write_addr_i   (write_addr_i),
        .write_data_i   (write_data_i),
        .start_i        (start_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .busy_o         (busy_o),
        .feed_done_o    (feed_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [0:N-1][DW-1:0] d;
        logic [N-1:0]         v;
        logic                 done;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [DW-1:0] a [N][N];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          e0 = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic void model_write(input int addr, input logic [DW-1:0] d);
        if (addr < DEPTH) a[addr / N][addr % N] = d;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) a[r][c] = '0;
    endfunction

    // Element (r,k) reaches lane r at step r+k; last frame is the done pulse.
    task automatic push_pass();
        exp_t e [2*N];
        for (int s = 0; s < 2 * N; s++) e[s] = '0;
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
`ifdef INPUT_FEEDER_TRANSPOSE_EN
                e[r + k].d[r] = a[k][r];
`else
                e[r + k].d[r] = a[r][k];
`endif
                e[r + k].v[r] = 1'b1;
            end
        end
        e[2 * N - 1].done = 1'b1;
        for (int s = 0; s < 2 * N; s++) q.push_back(e[s]);
    endtask

    always @(negedge clk_i) begin
        if (mon_en) begin
            if (valid_o != '0 || feed_done_o) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: actual valid %0h done %0b required no frame",
                             valid_o, feed_done_o);
                end else begin
                    mon_e = q.pop_front();
                    chk("lane_data", data_o, mon_e.d);
                    chk("lane_valid", valid_o, mon_e.v);
                    chk("feed_done", feed_done_o, mon_e.done);
                    chk("busy_in_frame", busy_o, 1);
                end
            end else begin
                chk("idle_data_zero", data_o, 0);
            end
        end
    end

    task automatic drive_write(input int addr, input logic [DW-1:0] d);
        write_enable_i = 1'b1;
        write_addr_i   = AW'(addr);
        write_data_i   = d;
        model_write(addr, d);
        @(posedge clk_i); #1;
        write_enable_i = 1'b0;
    endtask

    task automatic load_seq();
        for (int i = 0; i < DEPTH; i++) drive_write(i, DW'(i + 1));
    endtask

    task automatic start_pass(input bit wr, input int wa, input logic [DW-1:0] wd);
        start_i = 1'b1;
        if (wr) begin
            write_enable_i = 1'b1;
            write_addr_i   = AW'(wa);
            write_data_i   = wd;
            model_write(wa, wd);
        end
        push_pass();
        @(posedge clk_i); #1;
        e0             = cyc;
        start_i        = 1'b0;
        write_enable_i = 1'b0;
        chk("busy_after_start", busy_o, 1);
        chk("valid_after_start", valid_o, 0);
    endtask

    task automatic wait_done(input bit b2b);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 4 * N + 8 && !got; i++) begin
            @(negedge clk_i);
            if (feed_done_o) got = 1'b1;
        end
        chk("done_seen", got, 1);
        chk("done_latency", cyc - e0, 2 * N);
        if (b2b) begin
            start_i = 1'b1;
            push_pass();
        end
        @(posedge clk_i); #1;
        e0      = cyc;
        start_i = 1'b0;
        chk("busy_after_done", busy_o, b2b);
        chk("done_one_cycle", feed_done_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        model_clear();
        #2;
        chk("rst_data", data_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", feed_done_o, 0);
        #10 rstn_i = 1'b1;
        mon_en = 1'b1;
        @(posedge clk_i); #1;

        // Cleared SRAM: zeros with the normal valid pattern.
        start_pass(0, 0, 0);
        wait_done(0);

        load_seq();
        start_pass(0, 0, 0);
        wait_done(0);

        // Writes while feeding are dropped; replay still starts with 1.
        start_pass(0, 0, 0);
        write_enable_i = 1'b1;
        write_addr_i   = '0;
        write_data_i   = 32'd99;
        repeat (2) @(posedge clk_i);
        #1 write_enable_i = 1'b0;
        wait_done(0);
        start_pass(0, 0, 0);
        wait_done(0);

        start_pass(1, 0, 32'd42);
        wait_done(0);
        drive_write(0, 32'd1);

        drive_write(9, 32'hDEAD);
        drive_write(15, 32'hBEEF);
        start_pass(0, 0, 0);
        wait_done(0);

        start_pass(0, 0, 0);
        wait_done(1);
        wait_done(0);

        // Reset while step 2 is on the outputs.
        start_pass(0, 0, 0);
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b0;
        #1;
        q.delete();
        model_clear();
        chk("midrst_data", data_o, 0);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", feed_done_o, 0);
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        repeat (2 * N + 2) @(posedge clk_i);
        #1;
        start_pass(0, 0, 0);
        wait_done(0);

        for (int it = 0; it < 10; it++) begin
            bit b2b;
            int nw;
            nw = int'($urandom_range(1, 6));
            for (int w = 0; w < nw; w++)
                drive_write(int'($urandom_range(0, 15)), $urandom);
            start_pass($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 1) == 1) begin
                write_enable_i = 1'b1;
                write_addr_i   = AW'($urandom_range(0, 8));
                write_data_i   = $urandom;
                @(posedge clk_i);
                #1 write_enable_i = 1'b0;
            end
            b2b = ($urandom_range(0, 2) == 0);
            wait_done(b2b);
            if (b2b) wait_done(0);
        end

        repeat (3) @(posedge clk_i);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_skew_feeder.md
# input_skew_feeder

Input-side counterpart to the output collection SRAM. It holds one NxN operand matrix in a local SRAM that the host loads through a write port. On `start_i`, it streams the matrix into one edge of the systolic array with the diagonal skew the PEs need: lane r is delayed r cycles. It signals completion once the last element has left.

## Interface
- `N`, 3: matrix dimension (NxN), N >= 2
- `DATA_WIDTH`, 32: element width
- `SRAM_DEPTH`, N*N: storage words, row-major (addr = row*N + col)
- `clk_i`  in  1  single clock, rising edge
- `rstn_i`  in  1  reset, asynchronous, active-low
- `write_enable_i`  in  1  host write strobe
- `write_addr_i`  in  $clog2(SRAM_DEPTH)  host write address
- `write_data_i`  in  DATA_WIDTH  host write data
- `start_i`  in  1  begin a feed pass (level-sampled)
- `data_o`  out  [DATA_WIDTH-1:0] x [0:N-1]  per-lane operand into the array edge
- `valid_o`  out  N  per-lane valid
- `busy_o`  out  1  high while feeding
- `feed_done_o`  out  1  one-cycle pulse after the last step

## Operation
- States:
  - IDLE: accepts writes.
  - FEEDING: steps t = 0..2N-2.
  - DONE: one cycle, then IDLE.
- IDLE:
  - A write commits when write_enable_i is high and write_addr_i < SRAM_DEPTH. Out-of-range writes are dropped.
  - start_i high moves to FEEDING with t = 0.
- FEEDING, at step t, for each lane r:
  - k = t - r.
  - If 0 <= k < N: data_o[r] = A[r][k], valid_o[r] = 1.
  - Otherwise: data_o[r] = 0, valid_o[r] = 0.
- After step 2N-2: go to DONE. In DONE, all valid_o are 0 and feed_done_o = 1.
- Writes are ignored outside IDLE, with no error flag. start_i is ignored outside IDLE.
- A write and start_i in the same IDLE cycle: the write commits, and the pass uses the updated contents.
- busy_o = 1 in FEEDING and DONE.
- The step counter is $clog2(2N-1) bits. Lane index arithmetic uses a signed or widened compare, with no wrap on t < r.
- SRAM contents persist across passes. Re-issuing start_i replays the same matrix.

## Timing
- Reset (async assert): state IDLE, t = 0, all SRAM words 0, data_o all 0, valid_o 0, busy_o 0, feed_done_o 0.
- data_o and valid_o are registered.
- Call the edge that samples start_i high E0. Outputs for step t are visible after edge E(t+1).
  - First valid element (lane 0): 1 cycle after E0.
  - Last step: visible after E(2N-1).
- At E(2N): valid_o drops to 0, data_o goes to 0, feed_done_o goes high.
- At E(2N+1): feed_done_o low, busy_o low, state IDLE. start_i may be sampled on this same edge for back-to-back passes.
- Lane r is valid for exactly N consecutive cycles, starting r cycles after lane 0.
- Reset mid-feed: outputs go to 0 immediately (asynchronous). No feed_done_o pulse. SRAM is cleared.

## Configuration
- `INPUT_FEEDER_TRANSPOSE_EN`:
  - Defined: lane r carries A[k][r] (column-major read, weight-side feed from the top edge).
  - Undefined: lane r carries A[r][k].
- Write addressing is identical in both builds. Only the read index changes.

## Structure
- Shared package `systolic_pkg`:
  - `feeder_state_t` enum {IDLE, FEEDING, DONE} (2-bit).
  - Step-count width constant function of N.
- Single module, no sub-module. Skew comes from per-lane index arithmetic on the step counter, not from delay lines.

## Test plan
All scenarios use N=3 and A loaded row-major as 1..9.
- Basic feed:
  - Stimulus: load 1..9, pulse start.
  - Lane 0 data over steps 0..4: 1,2,3,0,0, valid 11100.
  - Lane 1: 0,4,5,6,0, valid 01110.
  - Lane 2: 0,0,7,8,9, valid 00111.
  - feed_done_o pulses at E6. busy_o is high E0..E6.
- Transpose build:
  - Stimulus: same load and start.
  - Lane 0: 1,4,7. Lane 1: 2,5,8 (starting step 1). Lane 2: 3,6,9 (starting step 2).
- Write during feed:
  - Stimulus: write addr 0 = 99 at step 1, then issue a second start.
  - Required: the second pass still emits 1 on lane 0 at step 0.
- Same-cycle write and start:
  - Stimulus: write addr 0 = 42 in the same IDLE cycle as start.
  - Required: lane 0 step 0 = 42.
- Out-of-range write:
  - Stimulus: write addr 9 (out of range).
  - Required: no SRAM change; replay matches the basic sequence.
- Reset mid-feed:
  - Stimulus: deassert rstn_i at step 2.
  - Required: outputs 0 at once, no feed_done_o, and a post-reset pass emits all zeros with normal valid pattern.
